// File: rtl/crc_byte_unloader.sv
// Serialises a captured CRC value onto a byte-wide valid/ready stream,
// LSB-lane-first or MSB-lane-first, with a one-cycle done pulse at the end.
module crc_byte_unloader #(
    parameter int MAX_BITS       = 32,
    parameter int MAX_BYTES      = 4,
    parameter int MAX_BYTE_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [MAX_BITS-1:0]       value,
    input  logic [MAX_BYTE_WIDTH-1:0] bytewidth,
    input  logic                      msb_first,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [7:0]                out_byte,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic                      dbg_state_o
);

    // Stream handshake: a byte moves on a rising edge where out_valid and
    // out_ready are both high; while out_valid is high and out_ready low,
    // out_byte/out_last/out_valid stay frozen.

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [MAX_BYTE_WIDTH-1:0] LAST_LANE = MAX_BYTE_WIDTH'(MAX_BYTES - 1);
    localparam logic [MAX_BYTE_WIDTH-1:0] ONE       = MAX_BYTE_WIDTH'(1);

    state_e                    state_q;
    logic [MAX_BITS-1:0]       data_q;
    logic [MAX_BYTE_WIDTH-1:0] idx_q;
    logic [MAX_BYTE_WIDTH-1:0] last_q;
    logic                      msb_q;
    logic                      out_valid_q;
    logic [7:0]                out_byte_q;
    logic                      out_last_q;
    logic                      done_q;

    logic [MAX_BYTE_WIDTH-1:0] bw_d;
    logic [MAX_BYTE_WIDTH-1:0] first_idx_d;
    logic [MAX_BYTE_WIDTH-1:0] next_idx_d;
    logic [7:0]                first_byte_d;
    logic [7:0]                next_byte_d;
    logic                      next_last_d;

    function automatic logic [7:0] lane(input logic [MAX_BITS-1:0] d,
                                        input logic [MAX_BYTE_WIDTH-1:0] i);
        logic [7:0] r;
        r = '0;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (i == MAX_BYTE_WIDTH'(k)) r = d[8*k +: 8];
        end
        return r;
    endfunction

    always_comb begin
        bw_d         = (bytewidth > LAST_LANE) ? LAST_LANE : bytewidth;
        first_idx_d  = msb_first ? bw_d : '0;
        first_byte_d = lane(value, first_idx_d);
        next_idx_d   = msb_q ? (idx_q - ONE) : (idx_q + ONE);
        next_byte_d  = lane(data_q, next_idx_d);
        // Ascending order ends on the captured width, descending on lane 0.
        next_last_d  = msb_q ? (next_idx_d == '0) : (next_idx_d == last_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            idx_q       <= '0;
            last_q      <= '0;
            msb_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q     <= SEND;
                        data_q      <= value;
                        last_q      <= bw_d;
                        msb_q       <= msb_first;
                        idx_q       <= first_idx_d;
                        out_valid_q <= 1'b1;
                        out_byte_q  <= first_byte_d;
                        out_last_q  <= (bw_d == '0);
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_byte_q  <= '0;
                            out_last_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            idx_q      <= next_idx_d;
                            out_byte_q <= next_byte_d;
                            out_last_q <= next_last_d;
                        end
                    end
                end
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_byte    = out_byte_q;
    assign out_last    = out_last_q;
    assign busy        = (state_q == SEND);
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_crc_byte_unloader.sv
// Bench for crc_byte_unloader: directed and random unloads checked through
// an expected-byte queue, plus stall, done and reset-abort checks.
module tb_crc_byte_unloader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] value;
  logic [1:0]  bytewidth;
  logic        msb_first;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];

  logic       mon_en = 1'b0;
  logic       prev_stall = 1'b0;
  logic [9:0] prev_obs = '0;
  logic       prev_final = 1'b0;

  crc_byte_unloader dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .bytewidth   (bytewidth),
    .msb_first   (msb_first),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_byte    (out_byte),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit, got running, expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          check("spurious_xfer", {22'd0, out_valid, out_last, out_byte}, 32'd0);
        end else begin
          check("sb_byte", {23'd0, out_last, out_byte}, {23'd0, exp_q.pop_front()});
        end
      end
      if (!out_valid) check("idle_zero", {23'd0, out_last, out_byte}, 32'd0);
      if (prev_stall) check("stall_hold", {22'd0, out_valid, out_last, out_byte}, {22'd0, prev_obs});
      check("done", done, prev_final);
      prev_stall = out_valid && !out_ready && !reset;
      prev_obs   = {out_valid, out_last, out_byte};
      prev_final = out_valid && out_ready && out_last && !reset;
    end
  end

  // driver tasks
  task automatic start_load(input logic [31:0] v, input logic [1:0] bw, input logic msb);
    int n;
    int ln;
    logic [31:0] vv;
    vv = v;
    n = int'(bw) + 1;
    for (int i = 0; i < n; i++) begin
      ln = msb ? (n - 1 - i) : i;
      exp_q.push_back({(i == n - 1), vv[8*ln +: 8]});
    end
    load = 1'b1;
    value = v;
    bytewidth = bw;
    msb_first = msb;
    @(posedge clk); #1;
    load = 1'b0;
    value = $urandom;
    bytewidth = 2'($urandom_range(0, 3));
    msb_first = 1'($urandom_range(0, 1));
    check("lat1_valid", out_valid, 1);
    check("busy_send", busy, 1);
    check("dbg_state", dbg_state, 1);
  endtask

  task automatic drain(input int mode, input int budget, output int cycles);
    int pat[4] = '{1, 0, 0, 1};
    cycles = 0;
    while (exp_q.size() > 0 && cycles < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (cycles < 4) ? 1'(pat[cycles]) : 1'b1;
      endcase
      @(posedge clk); #1;
      cycles++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    out_ready = 1'b0;
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    load = 1'b1;
    value = 32'hDEADBEEF;
    bytewidth = 2'd3;
    msb_first = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_byte", out_byte, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    load = 1'b0;
    out_ready = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", out_valid, 0);

    // LSB-first, back-to-back
    start_load(32'h12345678, 2'd3, 1'b0);
    drain(0, 20, cyc);
    check("b2b_cycles_lsb", cyc, 4);
    check("done_lsb", done, 1);
    check("busy_idle", busy, 0);
    @(posedge clk); #1;

    // MSB-first
    start_load(32'h12345678, 2'd3, 1'b1);
    drain(0, 20, cyc);
    check("b2b_cycles_msb", cyc, 4);
    @(posedge clk); #1;

    // two bytes with stalls on the second
    start_load(32'hAABBCCDD, 2'd1, 1'b0);
    drain(2, 20, cyc);
    check("stall_cycles", cyc, 4);
    check("done_after_cc", done, 1);
    @(posedge clk); #1;

    // single byte, then a load in the done cycle
    start_load(32'h000000A5, 2'd0, 1'b0);
    check("single_last", out_last, 1);
    check("single_byte", out_byte, 32'hA5);
    drain(0, 20, cyc);
    check("single_cycles", cyc, 1);
    check("done_single", done, 1);
    start_load(32'hCAFEF00D, 2'd2, 1'b1);
    drain(0, 20, cyc);
    check("load_in_done_cycles", cyc, 3);
    @(posedge clk); #1;

    // reset aborts after the 2nd byte; load during reset ignored
    start_load(32'h12345678, 2'd3, 1'b0);
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    reset = 1'b1;
    load = 1'b1;
    value = 32'h11223344;
    @(posedge clk); #1;
    exp_q.delete();
    check("abort_valid", out_valid, 0);
    check("abort_byte", out_byte, 0);
    check("abort_last", out_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    load = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_quiet", {30'd0, out_valid, done}, 0);
    end
    out_ready = 1'b0;

    // load pulses during SEND, including the final-transfer cycle, are ignored
    start_load(32'h0BADC0DE, 2'd3, 1'b1);
    load = 1'b1;
    value = 32'h55555555;
    bytewidth = 2'd0;
    @(posedge clk); #1;
    check("send_hold", out_byte, 32'h0B);
    drain(0, 20, cyc);
    load = 1'b0;
    check("ignore_cycles", cyc, 4);
    @(posedge clk); #1;
    check("ignore_no_restart", out_valid, 0);

    // random unloads with random back-pressure
    for (int t = 0; t < 12; t++) begin
      start_load($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      drain(1, 200, cyc);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
